uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx.sv | 145 ++++++++++++++
 tb/tb_uart_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and frame geometry.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, restartable so
// the tick phase can be aligned to an incoming start edge.
module uart_baud_tick #(
  parameter int DIV = 65
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (restart || cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(DIV - 1)) && !restart;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, presenting each byte on an
// AXI-Stream master port with single-cycle frame_err / overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 10_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rxd,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TICK_DIV = CLK_FREQ / (OVERSAMPLE * BAUD);
  localparam int BW       = $clog2(DATA_BITS);

  generate
    if (TICK_DIV < 1) begin : g_div_check
      $error("uart_rx: CLK_FREQ/(16*BAUD) must be at least 1");
    end
  endgenerate

  logic                 rxd_meta;
  logic                 rxd_sync;
  logic [1:0]           settle;
  logic                 armed;
  logic                 tick;
  logic                 restart;
  uart_state_t          state;
  logic [3:0]           ticks;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;

  // settle keeps the line from arming until the synchronizer holds post-reset
  // samples, so a line that is low at release never looks like a start edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      settle   <= 2'b00;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      settle   <= {settle[0], 1'b1};
    end
  end

  assign restart = (state == IDLE) && armed && !rxd_sync;

  uart_baud_tick #(
    .DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ticks     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      armed     <= 1'b0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (settle[1] && rxd_sync) begin
            armed <= 1'b1;
          end
          if (restart) begin
            state   <= START;
            ticks   <= '0;
            bit_cnt <= '0;
          end
        end

        START: begin
          if (tick) begin
            if (ticks == 4'(OVERSAMPLE / 2 - 1)) begin
              ticks <= '0;
              state <= rxd_sync ? IDLE : DATA;
            end else begin
              ticks <= ticks + 4'd1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (ticks == 4'(OVERSAMPLE - 1)) begin
              ticks   <= '0;
              shift   <= {rxd_sync, shift[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
              if (bit_cnt == BW'(DATA_BITS - 1)) begin
                state <= STOP;
              end
            end else begin
              ticks <= ticks + 4'd1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (ticks == 4'(OVERSAMPLE - 1)) begin
              ticks <= '0;
              state <= IDLE;
              if (!rxd_sync) begin
                frame_err <= 1'b1;
                armed     <= 1'b0;
              end else if (!m_tvalid || m_tready) begin
                m_tdata  <= shift;
                m_tvalid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              ticks <= ticks + 4'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a frame-level model of the holding register is
// checked against the DUT every cycle, plus literal per-scenario expectations.
module tb_uart_rx;

  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD     = 38400;
  localparam int TD       = CLK_FREQ / (16 * BAUD);
  localparam int BIT      = 16 * TD;
  // Byte appears 2 sync clocks + 1 register clock after the mid-stop sample,
  // which sits 9.5 bit times after the start edge.
  localparam int LAT      = 3 + (BIT * 19) / 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic       m_tready = 1'b0;
  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       frame_err;
  logic       overrun;

  always #50 clk = ~clk;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rxd      (rxd),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] data;
    logic       ok;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        cur_ev;
  logic       mv = 1'b0;
  logic [7:0] md = 8'h00;
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;
  logic [7:0] model_acc[$];
  logic [7:0] dut_acc[$];
  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         valid_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a one-entry holding register; a completed frame either loads it,
  // is dropped as an overrun, or (bad stop bit) raises frame_err.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mv = 1'b0;
      md = 8'h00;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      ev_q.delete();
    end else begin
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (mv && m_tready) begin
        model_acc.push_back(md);
        mv = 1'b0;
      end
      if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
        cur_ev = ev_q.pop_front();
        if (!cur_ev.ok) begin
          exp_fe = 1'b1;
        end else if (!mv) begin
          mv = 1'b1;
          md = cur_ev.data;
        end else begin
          exp_ov = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_tvalid", m_tvalid, mv);
    chk("m_tdata", m_tdata, md);
    chk("frame_err", frame_err, exp_fe);
    chk("overrun", overrun, exp_ov);
    if (m_tvalid && m_tready) dut_acc.push_back(m_tdata);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (m_tvalid) valid_cycles++;
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit counted);
    if (counted) ev_q.push_back('{cyc + LAT - 1, b, stop_bit});
    rxd = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BIT);
    end
    rxd = stop_bit;
    idle(BIT);
  endtask

  task automatic clear_logs();
    dut_acc.delete();
    model_acc.delete();
    fe_cnt = 0;
    ov_cnt = 0;
    valid_cycles = 0;
  endtask

  task automatic expect_bytes(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1);
    chk({tag, "_dut_count"}, dut_acc.size(), n);
    chk({tag, "_model_count"}, model_acc.size(), n);
    if (n > 0 && dut_acc.size() > 0) chk({tag, "_byte0"}, dut_acc[0], b0);
    if (n > 0 && model_acc.size() > 0) chk({tag, "_model_byte0"}, model_acc[0], b0);
    if (n > 1 && dut_acc.size() > 1) chk({tag, "_byte1"}, dut_acc[1], b1);
    if (n > 1 && model_acc.size() > 1) chk({tag, "_model_byte1"}, model_acc[1], b1);
  endtask

  task automatic expect_pulses(input string tag, input int fe, input int ov);
    chk({tag, "_frame_err_pulses"}, fe_cnt, fe);
    chk({tag, "_overrun_pulses"}, ov_cnt, ov);
  endtask

  initial begin
    @(posedge clk);
    #1;
    idle(3);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 8'h00);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    resetn = 1'b1;
    idle(5);

    // 0x55 with ready high: one byte, valid for a single cycle.
    clear_logs();
    m_tready = 1'b1;
    send_frame(8'h55, 1'b1, 1'b1);
    idle(BIT);
    expect_bytes("t1", 1, 8'h55, 8'h00);
    expect_pulses("t1", 0, 0);
    chk("t1_valid_cycles", valid_cycles, 1);
    $display("t1 0x55 ready=1: bytes=%0d fe=%0d ov=%0d", dut_acc.size(), fe_cnt, ov_cnt);

    // 0xA3 held, 0x3C overruns and is dropped.
    clear_logs();
    m_tready = 1'b0;
    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(BIT);
    chk("t2_hold_data", m_tdata, 8'hA3);
    chk("t2_hold_valid", m_tvalid, 1);
    m_tready = 1'b1;
    idle(4);
    expect_bytes("t2", 1, 8'hA3, 8'h00);
    expect_pulses("t2", 0, 1);
    $display("t2 0xA3+0x3C ready=0: bytes=%0d fe=%0d ov=%0d", dut_acc.size(), fe_cnt, ov_cnt);

    // 0xFF with a low stop bit, line held low, then a clean 0x12.
    clear_logs();
    send_frame(8'hFF, 1'b0, 1'b1);
    idle(3 * BIT);
    rxd = 1'b1;
    idle(BIT);
    send_frame(8'h12, 1'b1, 1'b1);
    idle(BIT);
    expect_bytes("t3", 1, 8'h12, 8'h00);
    expect_pulses("t3", 1, 0);
    $display("t3 bad stop then 0x12: bytes=%0d fe=%0d ov=%0d", dut_acc.size(), fe_cnt, ov_cnt);

    // Four-tick low glitch is rejected; a following frame still arrives.
    clear_logs();
    rxd = 1'b0;
    idle(4 * TD);
    rxd = 1'b1;
    idle(2 * BIT);
    chk("t4_glitch_no_byte", dut_acc.size(), 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(BIT);
    expect_bytes("t4", 1, 8'h5A, 8'h00);
    expect_pulses("t4", 0, 0);
    $display("t4 glitch then 0x5A: bytes=%0d fe=%0d ov=%0d", dut_acc.size(), fe_cnt, ov_cnt);

    // Reset during bit 4 with the line low, then 0x81 after the line idles high.
    clear_logs();
    rxd = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0);
      idle(BIT);
    end
    rxd = 1'b0;
    idle(BIT / 2);
    resetn = 1'b0;
    idle(3);
    chk("t5_rst_tvalid", m_tvalid, 0);
    chk("t5_rst_tdata", m_tdata, 8'h00);
    chk("t5_rst_frame_err", frame_err, 0);
    chk("t5_rst_overrun", overrun, 0);
    resetn = 1'b1;
    idle(BIT);
    rxd = 1'b1;
    idle(BIT);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(BIT);
    expect_bytes("t5", 1, 8'h81, 8'h00);
    expect_pulses("t5", 0, 0);
    $display("t5 reset mid-frame then 0x81: bytes=%0d fe=%0d ov=%0d", dut_acc.size(), fe_cnt, ov_cnt);

    // Back-to-back 0x00, 0xFF; ready pulses exactly on the 0xFF load cycle.
    clear_logs();
    m_tready = 1'b0;
    fork
      begin
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
      end
      begin : ready_pulse
        int t;
        t = cyc + 10 * BIT + LAT - 1;
        while (cyc < t) idle(1);
        m_tready = 1'b1;
        idle(1);
        m_tready = 1'b0;
      end
    join
    idle(BIT);
    chk("t6_hold_data", m_tdata, 8'hFF);
    m_tready = 1'b1;
    idle(4);
    expect_bytes("t6", 2, 8'h00, 8'hFF);
    expect_pulses("t6", 0, 0);
    $display("t6 0x00,0xFF back-to-back: bytes=%0d fe=%0d ov=%0d", dut_acc.size(), fe_cnt, ov_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
